sar_search: RTL and testbench

//  Binary-search initiator for the magnitude-compare interface. Drives candidate

---
 rtl/sar_search.sv | 121 ++++++++++++
 tb/tb_sar_search.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search: binary-search initiator that recovers a hidden value through a compare-only port
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             guess_vld,
    input  logic             cmp_vld,
    input  logic [2:0]       cmp_res,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    localparam int RW = $clog2(WIDTH + 2);
    localparam logic [RW-1:0] MAX_ROUNDS = RW'(WIDTH + 1);
    localparam logic signed [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t                  r_state, w_state_nx;
    logic signed [WIDTH:0]   r_lo, r_hi, w_lo_nx, w_hi_nx, w_lo_up, w_hi_dn;
    logic [RW-1:0]           r_rounds, w_rounds_nx, w_rounds_inc;
    logic [WIDTH-1:0]        r_guess, w_guess_nx, r_result, w_result_nx, w_mid;
    logic                    r_gvld, w_gvld_nx, r_found, w_found_nx, r_err, w_err_nx;
    logic                    w_take;

    assign w_mid        = WIDTH'(($unsigned(r_lo) + $unsigned(r_hi)) >> 1);
    assign w_lo_up      = $signed({1'b0, r_guess} + 1'b1);
    assign w_hi_dn      = $signed({1'b0, r_guess} - 1'b1);
    assign w_rounds_inc = r_rounds + 1'b1;
    assign w_take       = (r_state == WAIT) && cmp_vld && !r_gvld;

    assign guess     = r_guess;
    assign guess_vld = r_gvld;
    assign busy      = (r_state == ISSUE) || (r_state == WAIT);
    assign done      = (r_state == FIN);
    assign found     = r_found;
    assign err       = r_err;
    assign result    = r_result;

    // Next-state and search-window update; a response arriving alongside guess_vld is ignored
    always_comb begin
        w_state_nx  = r_state;
        w_lo_nx     = r_lo;
        w_hi_nx     = r_hi;
        w_rounds_nx = r_rounds;
        w_guess_nx  = r_guess;
        w_result_nx = r_result;
        w_found_nx  = r_found;
        w_err_nx    = r_err;
        w_gvld_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_lo_nx     = '0;
                    w_hi_nx     = HI_INIT;
                    w_rounds_nx = '0;
                    w_found_nx  = 1'b0;
                    w_err_nx    = 1'b0;
                    w_state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                w_guess_nx = w_mid;
                w_gvld_nx  = 1'b1;
                w_state_nx = WAIT;
            end
            WAIT: begin
                if (w_take) begin
                    w_rounds_nx = w_rounds_inc;
                    if (cmp_res == 3'b001) begin
                        w_result_nx = r_guess;
                        w_found_nx  = 1'b1;
                        w_state_nx  = FIN;
                    end else if (cmp_res == 3'b010 || cmp_res == 3'b100) begin
                        w_lo_nx = (cmp_res == 3'b010) ? w_lo_up : r_lo;
                        w_hi_nx = (cmp_res == 3'b100) ? w_hi_dn : r_hi;
                        w_err_nx   = (w_lo_nx > w_hi_nx) || (w_rounds_inc == MAX_ROUNDS);
                        w_found_nx = 1'b0;
                        w_state_nx = w_err_nx ? FIN : ISSUE;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_found_nx = 1'b0;
                        w_state_nx = FIN;
                    end
                end
            end
            FIN: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_rounds <= '0;
            r_guess  <= '0;
            r_gvld   <= 1'b0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_lo     <= w_lo_nx;
            r_hi     <= w_hi_nx;
            r_rounds <= w_rounds_nx;
            r_guess  <= w_guess_nx;
            r_gvld   <= w_gvld_nx;
            r_result <= w_result_nx;
            r_found  <= w_found_nx;
            r_err    <= w_err_nx;
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed-vector bench for sar_search with a scripted comparator responder
module tb_sar_search;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, cmp_vld = 1'b0;
    logic [2:0] cmp_res = 3'b000;
    logic [3:0] guess, result;
    logic       guess_vld, busy, done, found, err;
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    sar_search #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .guess(guess), .guess_vld(guess_vld),
        .cmp_vld(cmp_vld), .cmp_res(cmp_res), .busy(busy), .done(done),
        .found(found), .err(err), .result(result)
    );

    // mode: 0 honest, 1 code 000, 2 code 110, 3 always LT, 4 honest plus stray strobe/start, 5 always GT
    typedef struct {
        int tgt; int lat; int mode; int f; int e; int res; int nr; int gs;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic run(input int tgt, input int lat, input int mode,
                       output int f, output int e, output int res, output int nr,
                       output int gs, output int stab, output int ndone, output int tail);
        logic [3:0]  g;
        logic [2:0]  code;
        logic [19:0] gsv;
        f = 0; e = 0; res = 0; nr = 0; stab = 0; ndone = 0; tail = 0; gsv = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 300 && ndone == 0; c++) begin
            if (done) begin
                ndone = 1; f = int'(found); e = int'(err); res = int'(result);
            end else begin
                if (guess_vld) begin
                    g = guess;
                    if (nr < 5) gsv[nr*4 +: 4] = g;
                    nr++;
                    code = mode == 1 ? 3'b000 : mode == 2 ? 3'b110 : mode == 3 ? 3'b010 :
                           mode == 5 ? 3'b100 : int'(g) == tgt ? 3'b001 :
                           int'(g) < tgt ? 3'b010 : 3'b100;
                    if (mode == 4) begin
                        cmp_vld = 1'b1; cmp_res = 3'b000; start = 1'b1;
                    end
                    for (int k = 0; k < lat; k++) begin
                        @(negedge clk); cmp_vld = 1'b0; start = 1'b0;
                        if (guess !== g || guess_vld !== 1'b0 || busy !== 1'b1) stab++;
                    end
                    cmp_vld = 1'b1; cmp_res = code;
                end
                @(negedge clk); cmp_vld = 1'b0;
            end
        end
        gs = int'(gsv);
        if (ndone != 0) begin
            @(negedge clk); tail = int'(done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f, e, res, nr, gs, stab, nd, tail, cnt;
        tbl[0] = '{9,  1, 0, 1, 0, 9,  3, 'h009B7};
        tbl[1] = '{0,  1, 0, 1, 0, 0,  4, 'h00137};
        tbl[2] = '{15, 2, 0, 1, 0, 15, 5, 'hFEDB7};
        tbl[3] = '{9,  1, 1, 0, 1, 15, 1, 'h00007};
        tbl[4] = '{9,  3, 2, 0, 1, 15, 1, 'h00007};
        tbl[5] = '{9,  1, 3, 0, 1, 15, 5, 'hFEDB7};
        tbl[6] = '{9,  1, 5, 0, 1, 15, 4, 'h00137};
        tbl[7] = '{5,  3, 4, 1, 0, 5,  3, 'h00537};
        tbl[8] = '{6,  4, 0, 1, 0, 6,  4, 'h06537};

        repeat (3) @(negedge clk);
        chk("rst_guess", int'(guess), 0);
        chk("rst_guess_vld", int'(guess_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_result", int'(result), 0);
        rst = 1'b0;

        cnt = 0;
        @(negedge clk); cmp_vld = 1'b1; cmp_res = 3'b001;
        repeat (2) @(negedge clk);
        cmp_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || guess_vld !== 1'b0) cnt++;
            @(negedge clk);
        end
        chk("idle_cmp_vld_ignored", cnt, 0);

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].tgt, tbl[i].lat, tbl[i].mode, f, e, res, nr, gs, stab, nd, tail);
            chk($sformatf("v%0d_done", i), nd, 1);
            chk($sformatf("v%0d_found", i), f, tbl[i].f);
            chk($sformatf("v%0d_err", i), e, tbl[i].e);
            chk($sformatf("v%0d_result", i), res, tbl[i].res);
            chk($sformatf("v%0d_rounds", i), nr, tbl[i].nr);
            chk($sformatf("v%0d_guesses", i), gs, tbl[i].gs);
            chk($sformatf("v%0d_stable", i), stab, 0);
            chk($sformatf("v%0d_done_1cyc", i), tail, 0);
        end

        for (int t = 0; t < 16; t++) begin
            run(t, 1 + int'($urandom_range(0, 5)), 0, f, e, res, nr, gs, stab, nd, tail);
            chk($sformatf("sweep%0d_found", t), f, 1);
            chk($sformatf("sweep%0d_result", t), res, t);
            chk($sformatf("sweep%0d_stable", t), stab, 0);
            chk($sformatf("sweep%0d_rounds_le5", t), int'(nr <= 5 && nd == 1), 1);
        end

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (guess_vld !== 1'b1 && cnt < 10) begin
            @(negedge clk); cnt++;
        end
        chk("mid_rst_reached_wait", int'(guess_vld), 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_guess", int'(guess), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_found", int'(found), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_err", int'(err), 0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", cnt, 0);
        run(9, 1, 0, f, e, res, nr, gs, stab, nd, tail);
        chk("post_rst_found", f, 1);
        chk("post_rst_result", res, 9);
        chk("post_rst_rounds", nr, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
